// File: rtl/snn_readout.sv
// ---------------------------------------------------------------------------
// snn_readout
//
// Output-layer readout for the spiking network. One CLK edge is one SNN
// timestep. On an accepted start the block pulses the shared LIF reset for
// one cycle, counts spikes per output neuron over a WINDOW-timestep window,
// then runs a sequential argmax (one neuron per cycle, lowest index wins a
// tie) and posts the winner with a one-cycle done pulse.
//
// Handshake: start_i is a request that is sampled only while idle
// (busy_o=0). It is accepted on that edge, and busy_o rises after it.
// While busy_o=1, start_i is ignored and nothing is queued. done_o is a
// one-cycle valid pulse. class_out_o, max_count_o and none_o hold their
// values until the next done_o pulse or reset. start_i may be high in the
// done cycle, which starts the next inference with no gap cycle.
//
// Ports:
//   CLK          clock, one rising edge per timestep
//   nRST         synchronous active-low reset
//   start_i      inference request, sampled in IDLE only
//   spike_in_i   spike_out lines of the output LIF neurons, bit i = neuron i
//   lif_nrst_o   registered synchronous active-low reset for the LIF neurons
//   busy_o       high from start acceptance until the result is posted
//   done_o       one-cycle result-valid pulse
//   class_out_o  index of the winning neuron
//   max_count_o  spike count of the winning neuron
//   none_o       no neuron spiked during the window
//   state_o      current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module snn_readout #(
  parameter int N_OUT     = 4,
  parameter int WINDOW    = 16,
  parameter int CNT_WIDTH = 6
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start_i,
  input  logic [N_OUT-1:0]         spike_in_i,
  output logic                     lif_nrst_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(N_OUT)-1:0] class_out_o,
  output logic [CNT_WIDTH-1:0]     max_count_o,
  output logic                     none_o,
  output logic [1:0]               state_o
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam int TS_W  = $clog2(WINDOW + 1);

  localparam logic [TS_W-1:0]      TS_LAST  = TS_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_OUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACCUM = 2'd2,
    S_SCAN  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Per-neuron spike counters and window timestep counter
  logic [CNT_WIDTH-1:0] cnt_q [N_OUT];
  logic [CNT_WIDTH-1:0] cnt_d [N_OUT];
  logic [TS_W-1:0]      ts_q, ts_d;

  // Sequential argmax state
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;

  // Registered outputs
  logic                 lif_nrst_q, lif_nrst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     class_q, class_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic                 none_q, none_d;

  // Candidate best after considering the neuron under scan this cycle.
  // Strict compare keeps the earlier (lower) index on a tie.
  logic                 scan_upd;
  logic [CNT_WIDTH-1:0] cand_cnt;
  logic [IDX_W-1:0]     cand_idx;

  always_comb begin
    scan_upd = (cnt_q[scan_idx_q] > best_cnt_q);
    cand_cnt = scan_upd ? cnt_q[scan_idx_q] : best_cnt_q;
    cand_idx = scan_upd ? scan_idx_q : best_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ts_d       = ts_q;
    scan_idx_d = scan_idx_q;
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    max_d      = max_q;
    none_d     = none_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        for (int i = 0; i < N_OUT; i++) begin
          cnt_d[i] = '0;
        end
        ts_d    = '0;
        state_d = S_ACCUM;
      end

      S_ACCUM: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (spike_in_i[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ts_d = ts_q + 1'b1;
        if (ts_q == TS_LAST) begin
          // The WINDOW-th sample is taken on this edge; arm the scan.
          state_d    = S_SCAN;
          scan_idx_d = '0;
          best_cnt_d = '0;
          best_idx_d = '0;
        end
      end

      S_SCAN: begin
        best_cnt_d = cand_cnt;
        best_idx_d = cand_idx;
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == IDX_LAST) begin
          // Post the result from the candidate so the last neuron counts.
          class_d = cand_idx;
          max_d   = cand_cnt;
          none_d  = (cand_cnt == '0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they line up with it
    // after the edge: LIF reset low exactly during CLEAR, busy outside IDLE.
    busy_d     = (state_d != S_IDLE);
    lif_nrst_d = (state_d != S_CLEAR);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i] <= '0;
      end
      ts_q       <= '0;
      scan_idx_q <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
      lif_nrst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      class_q    <= '0;
      max_q      <= '0;
      none_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ts_q       <= ts_d;
      scan_idx_q <= scan_idx_d;
      best_cnt_q <= best_cnt_d;
      best_idx_q <= best_idx_d;
      lif_nrst_q <= lif_nrst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      class_q    <= class_d;
      max_q      <= max_d;
      none_q     <= none_d;
    end
  end

  assign lif_nrst_o  = lif_nrst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign class_out_o = class_q;
  assign max_count_o = max_q;
  assign none_o      = none_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_snn_readout.sv
// ---------------------------------------------------------------------------
// tb_snn_readout
//
// Two readouts share clock, reset, start and spikes: one with the default
// 6-bit counters and one with 3-bit counters, so saturation is exercised on
// every window. Directed vectors come from a table with hand-derived
// expectations; random windows are scored against a counting/argmax model.
// ---------------------------------------------------------------------------
module tb_snn_readout;

  localparam int N_OUT   = 4;
  localparam int WINDOW  = 16;
  localparam int DONE_AT = WINDOW + N_OUT + 1;
  localparam int SPW     = N_OUT * WINDOW;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic nRST;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic             start;
  logic [N_OUT-1:0] spike_in;

  logic       lif_nrst, busy, done, none;
  logic [1:0] class_out, state_dbg;
  logic [5:0] max_count;

  logic       lif_nrst3, busy3, done3, none3;
  logic [1:0] class_out3, state_dbg3;
  logic [2:0] max_count3;

  snn_readout #(.N_OUT(N_OUT), .WINDOW(WINDOW), .CNT_WIDTH(6)) dut (
    .CLK(CLK), .nRST(nRST), .start_i(start), .spike_in_i(spike_in),
    .lif_nrst_o(lif_nrst), .busy_o(busy), .done_o(done),
    .class_out_o(class_out), .max_count_o(max_count), .none_o(none),
    .state_o(state_dbg)
  );

  snn_readout #(.N_OUT(N_OUT), .WINDOW(WINDOW), .CNT_WIDTH(3)) dut3 (
    .CLK(CLK), .nRST(nRST), .start_i(start), .spike_in_i(spike_in),
    .lif_nrst_o(lif_nrst3), .busy_o(busy3), .done_o(done3),
    .class_out_o(class_out3), .max_count_o(max_count3), .none_o(none3),
    .state_o(state_dbg3)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];   // {class, max_count(6), none}
  logic [5:0] exp3_q[$];  // {class, max_count(3), none}

  // Last posted result, used to check that outputs hold between done pulses
  int prev_cls  = 0, prev_mx  = 0, prev_nn  = 0;
  int prev_cls3 = 0, prev_mx3 = 0, prev_nn3 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count spikes per neuron, clip at the counter ceiling, pick
  // the largest count with the lowest index on ties.
  task automatic model(input logic [SPW-1:0] sp, input int sat,
                       output int cls, output int mx, output int nn);
    int c [N_OUT];
    for (int n = 0; n < N_OUT; n++) begin
      c[n] = 0;
      for (int t = 0; t < WINDOW; t++) c[n] += int'(sp[t*N_OUT+n]);
      if (c[n] > sat) c[n] = sat;
    end
    cls = 0;
    mx  = 0;
    for (int n = 0; n < N_OUT; n++) begin
      if (c[n] > mx) begin
        mx  = c[n];
        cls = n;
      end
    end
    nn = (mx == 0) ? 1 : 0;
  endtask

  function automatic logic [SPW-1:0] add_spikes(input logic [SPW-1:0] sp,
                                                input int n, input int t0, input int t1);
    logic [SPW-1:0] r;
    r = sp;
    for (int t = t0; t <= t1; t++) r[t*N_OUT+n] = 1'b1;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called one step after an edge with both readouts idle (or in their done
  // cycle). Runs one full inference and scores the result.
  task automatic run_inf(input logic [SPW-1:0] sp, input bit noise);
    int lif_low;
    int done_edge, done_edge3;
    logic [8:0] e;
    logic [5:0] e3;

    start    = 1'b1;
    spike_in = N_OUT'($urandom_range(0, 15));
    @(posedge CLK); #1;  // E0
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("lif_nrst_after_start", int'(lif_nrst), 0);
    check("done_after_start", int'(done), 0);
    lif_low    = 1;
    done_edge  = 0;
    done_edge3 = 0;

    for (int k = 1; k <= DONE_AT + 10 && done_edge == 0; k++) begin
      if (k >= 2 && k <= WINDOW + 1) spike_in = sp[(k-2)*N_OUT +: N_OUT];
      else                           spike_in = N_OUT'($urandom_range(0, 15));
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge CLK); #1;
      if (!lif_nrst) lif_low++;
      if (done3) done_edge3 = k;
      if (done) begin
        done_edge = k;
      end else begin
        check("busy_held", int'(busy), 1);
        check("class_held", int'(class_out), prev_cls);
        check("max_held", int'(max_count), prev_mx);
        check("none_held", int'(none), prev_nn);
      end
    end
    start = 1'b0;

    check("done_edge", done_edge, DONE_AT);
    check("done_edge_w3", done_edge3, DONE_AT);
    check("lif_nrst_low_cycles", lif_low, 1);
    check("busy_in_done_cycle", int'(busy), 0);

    if (exp_q.size() == 0 || exp3_q.size() == 0) begin
      check("expect_queue_empty", 0, 1);
    end else begin
      e  = exp_q.pop_front();
      e3 = exp3_q.pop_front();
      check("class_out", int'(class_out), int'(e[8:7]));
      check("max_count", int'(max_count), int'(e[6:1]));
      check("none", int'(none), int'(e[0]));
      check("class_out_w3", int'(class_out3), int'(e3[5:4]));
      check("max_count_w3", int'(max_count3), int'(e3[3:1]));
      check("none_w3", int'(none3), int'(e3[0]));
      prev_cls  = int'(e[8:7]);  prev_mx  = int'(e[6:1]);  prev_nn  = int'(e[0]);
      prev_cls3 = int'(e3[5:4]); prev_mx3 = int'(e3[3:1]); prev_nn3 = int'(e3[0]);
    end
  endtask

  task automatic push_model(input logic [SPW-1:0] sp);
    int c, m, z;
    model(sp, 63, c, m, z);
    exp_q.push_back({c[1:0], m[5:0], z[0]});
    model(sp, 7, c, m, z);
    exp3_q.push_back({c[1:0], m[2:0], z[0]});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [SPW-1:0] sp;
    bit             noise;
    int             cls, mx, nn;
    int             cls3, mx3, nn3;
  } vec_t;

  vec_t tbl [5];
  logic [SPW-1:0] sp_tie;

  initial begin
    nRST     = 1'b0;
    start    = 1'b0;
    spike_in = '0;

    // Neuron 2 every timestep
    tbl[0].sp = '0;
    tbl[0].sp = add_spikes(tbl[0].sp, 2, 0, WINDOW - 1);
    tbl[0].noise = 1'b0;
    tbl[0].cls = 2; tbl[0].mx = 16; tbl[0].nn = 0;
    tbl[0].cls3 = 2; tbl[0].mx3 = 7; tbl[0].nn3 = 0;
    // Tie: neurons 1 and 3 five spikes, neuron 0 two spikes
    sp_tie = '0;
    sp_tie = add_spikes(sp_tie, 1, 0, 4);
    sp_tie = add_spikes(sp_tie, 3, 6, 10);
    sp_tie = add_spikes(sp_tie, 0, 12, 13);
    tbl[1].sp = sp_tie;
    tbl[1].noise = 1'b1;
    tbl[1].cls = 1; tbl[1].mx = 5; tbl[1].nn = 0;
    tbl[1].cls3 = 1; tbl[1].mx3 = 5; tbl[1].nn3 = 0;
    // Neuron 0 every timestep: saturates the 3-bit counters
    tbl[2].sp = '0;
    tbl[2].sp = add_spikes(tbl[2].sp, 0, 0, WINDOW - 1);
    tbl[2].noise = 1'b0;
    tbl[2].cls = 0; tbl[2].mx = 16; tbl[2].nn = 0;
    tbl[2].cls3 = 0; tbl[2].mx3 = 7; tbl[2].nn3 = 0;
    // Silence
    tbl[3].sp = '0;
    tbl[3].noise = 1'b1;
    tbl[3].cls = 0; tbl[3].mx = 0; tbl[3].nn = 1;
    tbl[3].cls3 = 0; tbl[3].mx3 = 0; tbl[3].nn3 = 1;
    // Neuron 2 x8, neuron 3 x12: both clip to 7 in 3 bits, tie goes to 2
    tbl[4].sp = '0;
    tbl[4].sp = add_spikes(tbl[4].sp, 2, 0, 7);
    tbl[4].sp = add_spikes(tbl[4].sp, 3, 0, 11);
    tbl[4].noise = 1'b0;
    tbl[4].cls = 3; tbl[4].mx = 12; tbl[4].nn = 0;
    tbl[4].cls3 = 2; tbl[4].mx3 = 7; tbl[4].nn3 = 0;

    // ---- reset values ----
    repeat (3) @(posedge CLK);
    #1;
    check("rst_lif_nrst", int'(lif_nrst), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_class", int'(class_out), 0);
    check("rst_max", int'(max_count), 0);
    check("rst_none", int'(none), 0);
    check("rst_none_w3", int'(none3), 0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("rel_lif_nrst", int'(lif_nrst), 1);
    check("rel_busy", int'(busy), 0);

    // ---- directed table, back-to-back ----
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({tbl[i].cls[1:0], tbl[i].mx[5:0], tbl[i].nn[0]});
      exp3_q.push_back({tbl[i].cls3[1:0], tbl[i].mx3[2:0], tbl[i].nn3[0]});
      run_inf(tbl[i].sp, tbl[i].noise);
    end

    // done is a single-cycle pulse and results hold afterwards
    spike_in = '1;
    @(posedge CLK); #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("class_hold_idle", int'(class_out), prev_cls);
    check("max_hold_idle", int'(max_count), prev_mx);

    // ---- randomized windows against the model ----
    for (int r = 0; r < 20; r++) begin
      logic [SPW-1:0] sp;
      int dens [N_OUT];
      for (int n = 0; n < N_OUT; n++) dens[n] = $urandom_range(0, 100);
      sp = '0;
      for (int t = 0; t < WINDOW; t++)
        for (int n = 0; n < N_OUT; n++)
          sp[t*N_OUT+n] = ($urandom_range(0, 99) < dens[n]);
      push_model(sp);
      run_inf(sp, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
    end

    // ---- reset in the middle of ACCUM (timestep 7) ----
    start    = 1'b1;
    spike_in = '1;
    @(posedge CLK); #1;  // E0
    start = 1'b0;
    repeat (8) begin     // E1 (CLEAR), E2..E8 = timesteps 0..6
      @(posedge CLK); #1;
    end
    nRST = 1'b0;
    @(posedge CLK); #1;
    check("mid_rst_lif_nrst", int'(lif_nrst), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_class", int'(class_out), 0);
    check("mid_rst_max", int'(max_count), 0);
    check("mid_rst_none", int'(none), 0);
    check("mid_rst_max_w3", int'(max_count3), 0);
    prev_cls = 0; prev_mx = 0; prev_nn = 0;
    prev_cls3 = 0; prev_mx3 = 0; prev_nn3 = 0;
    nRST = 1'b1;
    for (int k = 0; k < DONE_AT; k++) begin
      @(posedge CLK); #1;
      if (k == 0) check("mid_rel_lif_nrst", int'(lif_nrst), 1);
      check("no_done_after_rst", int'(done | done3), 0);
      check("idle_after_rst", int'(busy), 0);
    end
    exp_q.push_back({2'd1, 6'd5, 1'b0});
    exp3_q.push_back({2'd1, 3'd5, 1'b0});
    run_inf(sp_tie, 1'b0);

    check("queue_drained", exp_q.size() + exp3_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_readout.md
# snn_readout

Output-layer readout for the spiking network. It consumes the `spike_out` lines of N_OUT LIF output neurons over a fixed window of WINDOW timesteps and counts spikes per neuron. It then picks the neuron with the most spikes (winner-take-all) and reports its index as the classification result. It also drives the shared LIF reset, so each inference window starts from cleared membrane potentials.

## Interface
- N_OUT, 4: number of output neurons / classes; ≥2.
- WINDOW, 16: timesteps (CLK cycles) per inference window; ≥1.
- CNT_WIDTH, 6: width of each per-neuron spike counter.
- CLK  in  1  clock; one rising edge = one SNN timestep.
- nRST  in  1  reset; synchronous, active-low.
- start  in  1  request an inference; sampled only in IDLE.
- spike_in  in  N_OUT  spike_out lines of the output LIF neurons; bit i = neuron i.
- lif_nrst  out  1  registered synchronous active-low reset for the LIF neurons.
- busy  out  1  high from start acceptance until the result is posted.
- done  out  1  one-cycle result-valid pulse.
- class_out  out  clog2(N_OUT)  winning neuron index; held until the next done.
- max_count  out  CNT_WIDTH  spike count of the winner; held with class_out.
- none  out  1  no neuron spiked in the window; held with class_out.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, SCAN.
- IDLE:
  - lif_nrst=1, busy=0.
  - start=1 → CLEAR.
  - start is ignored in every other state; there is no queueing.
- CLEAR (1 cycle):
  - lif_nrst=0, so the LIF neurons reset on the next edge.
  - Spike counters and the timestep counter are zeroed.
  - Next state: ACCUM.
- ACCUM (WINDOW cycles):
  - lif_nrst=1.
  - Each edge: for every i with spike_in[i]=1, cnt[i] += 1, saturating at 2^CNT_WIDTH-1 (no wrap).
  - The timestep counter (width clog2(WINDOW+1)) increments each edge.
  - After the WINDOW-th sample → SCAN.
- SCAN (N_OUT cycles):
  - Sequential argmax, one neuron per cycle, index 0..N_OUT-1.
  - best_cnt/best_idx start at 0/0.
  - Update only when cnt[i] > best_cnt (strict), so ties resolve to the lowest index.
  - spike_in is ignored.
  - After index N_OUT-1: register class_out=best_idx, max_count=best_cnt, none=(best_cnt==0); pulse done; → IDLE.
- All counts zero gives class_out=0, max_count=0, none=1.
- Reset at any time:
  - FSM goes to IDLE and all counters clear.
  - Outputs take reset values: lif_nrst=0, busy=0, done=0, class_out=0, max_count=0, none=0.
  - lif_nrst returns to 1 on the first edge after nRST deasserts.

## Timing
- All outputs are registered.
- Start accepted at edge E0 → busy=1 and lif_nrst=0 after E0.
- E1: LIF neurons reset; lif_nrst=1; enter ACCUM.
- Spikes are sampled at edges E2..E(WINDOW+1), exactly WINDOW samples.
- SCAN edges are E(WINDOW+2)..E(WINDOW+N_OUT+1).
- At E(WINDOW+N_OUT+1): done=1, busy=0, results updated. With defaults this is 21 edges after E0.
- done is high for exactly one cycle.
- start=1 in the done cycle is accepted, giving back-to-back inferences with no gap cycle.
- class_out, max_count and none change only at the done edge or on reset.

## Test plan
- **Reset values:** hold nRST=0 for 3 cycles → lif_nrst=0, busy=0, done=0, class_out=0, max_count=0, none=0. One edge after release → lif_nrst=1.
- **Basic classification** (defaults): pulse start, then drive spike_in=4'b0100 for all 16 ACCUM cycles → done exactly 21 edges after the start edge, class_out=2, max_count=16, none=0. lif_nrst low for exactly one cycle.
- **Tie-break:** neurons 1 and 3 each spike 5 times, neuron 0 spikes 2 times → class_out=1, max_count=5.
- **Saturation and silence:**
  - CNT_WIDTH=3, WINDOW=16, neuron 0 spikes every cycle → max_count=7, class_out=0.
  - A second run with spike_in=0 → none=1, class_out=0, max_count=0.
- **Handshake:**
  - start re-asserted during ACCUM and SCAN → ignored; single done pulse.
  - start in the done cycle → new CLEAR on the next edge. busy stays 0 for only the done cycle.
  - Spikes presented during CLEAR/SCAN are not counted.
- **Reset mid-operation:** nRST=0 during ACCUM at timestep 7 → IDLE with all outputs at reset values, and no done pulse. A following start yields a result counting only the new window's spikes.
